// File: rtl/arb_pkg.sv
// Shared constants and helpers for the valid/ready source arbiter.
package arb_pkg;

   localparam int ARB_MODE_FP = 0;
   localparam int ARB_MODE_RR = 1;
   localparam int HSK_PASS    = 0;
   localparam int HSK_REG     = 1;

   // OR-reduction encoder; the result is only meaningful for one-hot or zero input.
   function automatic logic [31:0] onehot_to_idx(input logic [31:0] onehot);
      logic [31:0] idx;
      idx = '0;
      for (int i = 0; i < 32; i++) begin
         if (onehot[i]) idx = idx | 32'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/arb_rr_sel.sv
// Round-robin select: first valid source at or above ptr, wrapping to index 0.
module arb_rr_sel #(
   parameter int WIDTH    = 4,
   parameter int ID_WIDTH = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0]    v_vld,
   input  logic [ID_WIDTH-1:0] ptr,
   output logic [WIDTH-1:0]    grant
);

   localparam int DW = 2 * WIDTH;

   logic [DW-1:0] req_dbl;
   logic [DW-1:0] mask;
   logic [DW-1:0] req_masked;
   logic [DW-1:0] first_hot;

   // The upper copy catches the wrap: when nothing at or above ptr is valid,
   // its lowest set bit is the lowest valid index overall.
   always_comb begin
      req_dbl    = {v_vld, v_vld};
      mask       = ~((DW'(1) << ptr) - DW'(1));
      req_masked = req_dbl & mask;
      first_hot  = req_masked & (~req_masked + DW'(1));
      grant      = first_hot[WIDTH-1:0] | first_hot[DW-1:WIDTH];
   end

endmodule

// File: rtl/onehot_mux.sv
// AND-OR multiplexer selected by a one-hot (or all-zero) vector.
module onehot_mux #(
   parameter int WIDTH     = 4,
   parameter int PLD_WIDTH = 32
) (
   input  logic [WIDTH-1:0]     sel,
   input  logic [PLD_WIDTH-1:0] din [WIDTH],
   output logic [PLD_WIDTH-1:0] dout
);

   logic [PLD_WIDTH-1:0] masked [WIDTH];

   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_mask
      assign masked[gi] = din[gi] & {PLD_WIDTH{sel[gi]}};
   end

   always_comb begin
      dout = '0;
      for (int i = 0; i < WIDTH; i++) begin
         dout = dout | masked[i];
      end
   end

endmodule

// File: rtl/arb_vrp_pipe.sv
// WIDTH valid/ready sources merged onto one master channel, fixed-priority or
// round-robin, with either a combinational pass path or a one-entry output buffer.
module arb_vrp_pipe
   import arb_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter int PLD_WIDTH = 32,
   parameter int MODE      = 1,
   parameter int HSK_MODE  = 1,
   parameter int ID_WIDTH  = $clog2(WIDTH)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [WIDTH-1:0]     v_vld_s,
   output logic [WIDTH-1:0]     v_rdy_s,
   input  logic [PLD_WIDTH-1:0] v_pld_s [WIDTH],
   output logic                 vld_m,
   input  logic                 rdy_m,
   output logic [PLD_WIDTH-1:0] pld_m,
   output logic [ID_WIDTH-1:0]  id_m
);

   if (WIDTH < 2 || WIDTH > 32 ||
       (MODE != ARB_MODE_FP && MODE != ARB_MODE_RR) ||
       (HSK_MODE != HSK_PASS && HSK_MODE != HSK_REG) ||
       ID_WIDTH < $clog2(WIDTH)) begin : g_param_check
      $error("arb_vrp_pipe: illegal parameter set");
   end

   logic [ID_WIDTH-1:0]  ptr_reg, ptr_next, ptr_sel, grant_idx;
   logic [WIDTH-1:0]     arb_grant, grant;
   logic [PLD_WIDTH-1:0] mux_pld;
   logic                 src_hsk;

   assign ptr_sel = (MODE == ARB_MODE_RR) ? ptr_reg : '0;

   arb_rr_sel #(.WIDTH(WIDTH), .ID_WIDTH(ID_WIDTH)) u_rr_sel (
      .v_vld (v_vld_s),
      .ptr   (ptr_sel),
      .grant (arb_grant)
   );

   onehot_mux #(.WIDTH(WIDTH), .PLD_WIDTH(PLD_WIDTH)) u_pld_mux (
      .sel  (grant),
      .din  (v_pld_s),
      .dout (mux_pld)
   );

   assign grant_idx = ID_WIDTH'(onehot_to_idx(32'(grant)));
   assign src_hsk   = |(v_vld_s & v_rdy_s);

   // Pointer wraps modulo WIDTH, not modulo 2**ID_WIDTH.
   always_comb begin
      ptr_next = ptr_reg;
      if (src_hsk) begin
         ptr_next = (grant_idx == ID_WIDTH'(WIDTH - 1)) ? '0 : grant_idx + ID_WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ptr_reg <= '0;
      else        ptr_reg <= ptr_next;
   end

   if (HSK_MODE == HSK_PASS) begin : g_pass
      logic                lock_vld_reg, lock_vld_next;
      logic [ID_WIDTH-1:0] lock_id_reg, lock_id_next;
      logic                lock_hold;

      // A lock whose source withdrew vld is ignored so arbitration reruns this cycle.
      assign lock_hold = lock_vld_reg && v_vld_s[lock_id_reg];
      assign grant     = lock_hold ? (WIDTH'(1) << lock_id_reg) : arb_grant;
      assign vld_m     = |v_vld_s;
      assign pld_m     = mux_pld;
      assign id_m      = grant_idx;
      assign v_rdy_s   = grant & {WIDTH{rdy_m}};

      always_comb begin
         lock_vld_next = vld_m && !rdy_m;
         lock_id_next  = lock_id_reg;
         if (vld_m && !rdy_m) lock_id_next = grant_idx;
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            lock_vld_reg <= 1'b0;
            lock_id_reg  <= '0;
         end else begin
            lock_vld_reg <= lock_vld_next;
            lock_id_reg  <= lock_id_next;
         end
      end
   end else begin : g_reg
      logic                 buf_vld_reg;
      logic [PLD_WIDTH-1:0] buf_pld_reg;
      logic [ID_WIDTH-1:0]  buf_id_reg;
      logic                 accept;

      // Refuse sources while in reset so no transfer is lost to the buffer clear.
      assign accept  = rst_n && (!buf_vld_reg || rdy_m);
      assign grant   = arb_grant;
      assign v_rdy_s = grant & {WIDTH{accept}};
      assign vld_m   = buf_vld_reg;
      assign pld_m   = buf_pld_reg;
      assign id_m    = buf_id_reg;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            buf_vld_reg <= 1'b0;
            buf_pld_reg <= '0;
            buf_id_reg  <= '0;
         end else if (src_hsk) begin
            buf_vld_reg <= 1'b1;
            buf_pld_reg <= mux_pld;
            buf_id_reg  <= grant_idx;
         end else if (buf_vld_reg && rdy_m) begin
            buf_vld_reg <= 1'b0;
         end
      end
   end

endmodule

// File: doc/arb_vrp_pipe.md
Name: arb_vrp_pipe

Overview:
- Parametrised successor to the team's combinational valid/ready fixed-priority arbiter.
- Merges WIDTH valid/ready source channels onto one master channel.
- Selectable arbitration mode: fixed priority or round robin.
- Selectable handshake mode: combinational pass or 1-cycle registered.
- Adds grant lock under back-pressure and a granted-source index output.
- Sits in front of shared request ports (icache miss/refill queues, bus masters).

Parameters:
- WIDTH, 4: number of source channels; legal range 2..32.
- PLD_WIDTH, 32: payload width per channel.
- MODE, 1: 0 = fixed priority (index 0 highest); 1 = round robin.
- HSK_MODE, 1: 0 = pass (0-cycle, grant lock); 1 = 1-cycle output register.
- ID_WIDTH, $clog2(WIDTH): width of granted-index output.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- v_vld_s  input  WIDTH  per-source valid.
- v_rdy_s  output  WIDTH  per-source ready; at most one bit set.
- v_pld_s  input  PLD_WIDTH x [WIDTH]  per-source payload, unpacked array.
- vld_m  output  1  master valid.
- rdy_m  input  1  master ready.
- pld_m  output  PLD_WIDTH  master payload.
- id_m  output  ID_WIDTH  index of the source whose payload is on pld_m.

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Source handshake: source i transfers when v_vld_s[i] && v_rdy_s[i]. Master transfers when vld_m && rdy_m.
- Source protocol: once vld is asserted, a source holds vld and pld until it sees rdy.
- Arbitration, MODE 0: grant the lowest-index valid source.
- Arbitration, MODE 1: pointer ptr (ID_WIDTH bits, reset 0). Search from ptr upward and wrap, granting the first valid source.
  - On a source handshake with index g: ptr <= (g == WIDTH-1) ? 0 : g+1.
  - No handshake: ptr holds.
  - Wrap is mod WIDTH, not mod 2^ID_WIDTH (e.g. WIDTH=3 wraps 2 -> 0).
- Grant is one-hot or zero. No valid source means zero grant, and ptr does not move.

HSK_MODE 0 (pass):
- vld_m = |v_vld_s.
- pld_m = mux(grant).
- id_m = encode(grant).
- v_rdy_s = grant & {WIDTH{rdy_m}}.
- Latency 0.
- Grant lock:
  - If vld_m && !rdy_m, register lock_vld=1 and lock_id=granted index.
  - While lock_vld, the grant is forced to lock_id. Newly valid higher-priority sources are ignored.
  - Clear lock_vld on master handshake.
  - If the locked source drops vld (protocol violation), clear the lock and re-arbitrate combinationally in the same cycle.
  - Reset: lock_vld=0, lock_id=0.

HSK_MODE 1 (registered):
- One-entry output buffer: buf_vld, buf_pld, buf_id.
- accept = !buf_vld || rdy_m.
- v_rdy_s = grant & {WIDTH{accept}}.
- On source handshake: buf_vld<=1, buf_pld<=v_pld_s[g], buf_id<=g.
- Else on master handshake: buf_vld<=0.
- Outputs: vld_m=buf_vld, pld_m=buf_pld, id_m=buf_id.
- Latency 1 cycle. Full throughput: one transfer per cycle while rdy_m=1.
- Full buffer with rdy_m=0: all v_rdy_s=0 and the buffer holds.
- Simultaneous master drain and source accept in one cycle: the buffer reloads and buf_vld stays 1.
- No combinational path from rdy_m to vld_m or pld_m. The only combinational path is rdy_m -> v_rdy_s.

Reset values (asynchronous, every output):
- HSK_MODE 1: vld_m=0, pld_m=0, id_m=0, v_rdy_s=0.
- HSK_MODE 0: outputs are combinational from inputs. ptr=0 and lock cleared.
- Reset mid-transfer: the in-flight buffer entry is discarded, and arbitration restarts from ptr=0 after deassert.

Other rules:
- A single-source valid is granted in either mode, regardless of ptr.
- Illegal parameter values (WIDTH<2, MODE>1, HSK_MODE>1) cause an elaboration error.

Decomposition:
- Package arb_pkg holds:
  - constants ARB_MODE_FP=0, ARB_MODE_RR=1, HSK_PASS=0, HSK_REG=1;
  - a function onehot_to_idx.
- Sub-module arb_rr_sel: combinational masked-priority round-robin select.
  - Inputs: v_vld, ptr.
  - Output: one-hot grant.
  - Implementation: double-width priority trick.
  - MODE 0 ties ptr to 0.
- Payload mux: reuse the team's one-hot mux common block.
- Top level holds ptr, lock and buffer registers.

Test Plan (WIDTH=4, PLD_WIDTH=32, payload = 0xA0+i):
1. MODE1/HSK1, all 4 valid, rdy_m=1 continuously -> id_m sequence 0,1,2,3,0 starting cycle 1 after reset release; pld_m 0xA0,0xA1,0xA2,0xA3,0xA0; vld_m held 1.
2. MODE0/HSK0, v_vld_s=4'b1100, rdy_m=0 for 3 cycles, source 0 raises vld in cycle 2 -> id_m stays 2 (lock), v_rdy_s=0; when rdy_m=1, v_rdy_s=4'b0100 and the next grant goes to 0.
3. MODE1/HSK1, buffer full, rdy_m=0 for 5 cycles -> v_rdy_s=0, pld_m stable at 0xA1. Then rdy_m=1 with source 3 valid -> drain and reload in the same cycle; vld_m never drops.
4. MODE1/HSK0, WIDTH=3 build, only source 2 valid then all valid -> grant 2, ptr wraps to 0, next grants 0,1,2.
5. Reset asserted while buf_vld=1 in HSK1 -> vld_m=0 asynchronously. After release, first grant is index 0 with 4'b1111 valid.
6. MODE1/HSK1, random vld/rdy for 10k cycles, scoreboard per source -> no loss or duplication, payload order per source preserved, no source starved more than WIDTH handshakes.
